// File: rtl/barrel_shift_sequencer.sv
// Step-rate controller for the 8-bit barrel-shifter datapath: button edge detection,
// load/config capture and prescaled single-step shift strobes.
module barrel_shift_sequencer #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_load,
    output logic       busy,
    output logic       done,
    output logic       sh_load,
    output logic [7:0] sh_load_data,
    output logic       sh_en,
    output logic       sh_dir,
    output logic       sh_rot,
    output logic [2:0] sh_amt,
    output logic [2:0] steps_left
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 32'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic          counted_r, counted_nx_s;
    logic          prev_start_r, prev_stop_r, prev_load_r;
    logic          start_edge_s, stop_edge_s, load_edge_s;
    logic          busy_nx_s, done_nx_s, load_nx_s, en_nx_s;
    logic          dir_nx_s, rot_nx_s;
    logic [7:0]    data_nx_s;
    logic [2:0]    amt_nx_s, steps_nx_s;

    assign start_edge_s = btn_start & ~prev_start_r;
    assign stop_edge_s  = btn_stop  & ~prev_stop_r;
    assign load_edge_s  = btn_load  & ~prev_load_r;

    // Next-state and next-output decode; stop outranks load, load outranks start.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        counted_nx_s = counted_r;
        busy_nx_s    = busy;
        done_nx_s    = 1'b0;
        load_nx_s    = 1'b0;
        en_nx_s      = 1'b0;
        data_nx_s    = sh_load_data;
        dir_nx_s     = sh_dir;
        rot_nx_s     = sh_rot;
        amt_nx_s     = sh_amt;
        steps_nx_s   = steps_left;
        case (state_r)
            ST_IDLE: begin
                if (stop_edge_s) begin
                    state_nx_s = ST_IDLE;
                end else if (load_edge_s) begin
                    data_nx_s = sw;
                    load_nx_s = 1'b1;
                end else if (start_edge_s) begin
                    amt_nx_s     = sw[2:0];
                    dir_nx_s     = sw[3];
                    rot_nx_s     = sw[4];
                    steps_nx_s   = sw[7:5];
                    counted_nx_s = (sw[7:5] != 3'd0);
                    cnt_nx_s     = '0;
                    busy_nx_s    = 1'b1;
                    state_nx_s   = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_edge_s) begin
                    busy_nx_s  = 1'b0;
                    state_nx_s = ST_IDLE;
                end else if (counted_r && sh_en && (steps_left == 3'd0)) begin
                    // the final strobe is on the outputs now; close the run
                    busy_nx_s  = 1'b0;
                    done_nx_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nx_s = '0;
                    en_nx_s  = 1'b1;
                    if (counted_r) begin
                        steps_nx_s = steps_left - 3'd1;
                    end else begin
                        steps_nx_s = 3'd0;
                    end
                end else begin
                    cnt_nx_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                busy_nx_s  = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, prescaler, button history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            counted_r    <= 1'b0;
            prev_start_r <= 1'b1;
            prev_stop_r  <= 1'b1;
            prev_load_r  <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            sh_load      <= 1'b0;
            sh_load_data <= 8'h00;
            sh_en        <= 1'b0;
            sh_dir       <= 1'b0;
            sh_rot       <= 1'b0;
            sh_amt       <= 3'd0;
            steps_left   <= 3'd0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            counted_r    <= counted_nx_s;
            prev_start_r <= btn_start;
            prev_stop_r  <= btn_stop;
            prev_load_r  <= btn_load;
            busy         <= busy_nx_s;
            done         <= done_nx_s;
            sh_load      <= load_nx_s;
            sh_load_data <= data_nx_s;
            sh_en        <= en_nx_s;
            sh_dir       <= dir_nx_s;
            sh_rot       <= rot_nx_s;
            sh_amt       <= amt_nx_s;
            steps_left   <= steps_nx_s;
        end
    end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Self-checking bench: two sequencers (TICK_DIV 4 and 1) share stimulus and are
// checked every cycle against a timing-formula model plus directed literal checks.
module tb_barrel_shift_sequencer;

    logic       clk, rst_n;
    logic [7:0] sw;
    logic       btn_start, btn_stop, btn_load;
    logic [1:0] busy, done, sh_load, sh_en, sh_dir, sh_rot;
    logic [7:0] ld [2];
    logic [2:0] amt [2];
    logic [2:0] steps [2];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on = 1'b0;

    barrel_shift_sequencer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_load(btn_load),
        .busy(busy[0]), .done(done[0]), .sh_load(sh_load[0]), .sh_load_data(ld[0]),
        .sh_en(sh_en[0]), .sh_dir(sh_dir[0]), .sh_rot(sh_rot[0]), .sh_amt(amt[0]),
        .steps_left(steps[0])
    );

    barrel_shift_sequencer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_load(btn_load),
        .busy(busy[1]), .done(done[1]), .sh_load(sh_load[1]), .sh_load_data(ld[1]),
        .sh_en(sh_en[1]), .sh_dir(sh_dir[1]), .sh_rot(sh_rot[1]), .sh_amt(amt[1]),
        .steps_left(steps[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: a run is described by its first busy cycle t, its step count N and TICK_DIV.
    int         m_cyc;
    bit         p_start, p_stop, p_load, es, ep, el;
    bit         m_busy [2], m_done [2], m_load [2], m_en [2], m_dir [2], m_rot [2];
    logic [7:0] m_data [2];
    int         m_amt [2], m_steps [2], m_t [2], m_n [2];
    int         k, td;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", nm, m_cyc, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            p_start = 1'b1; p_stop = 1'b1; p_load = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_load[i] = 0; m_en[i] = 0;
                m_dir[i] = 0; m_rot[i] = 0; m_data[i] = 8'h00;
                m_amt[i] = 0; m_steps[i] = 0; m_t[i] = 0; m_n[i] = 0;
            end
        end else begin
            m_cyc++;
            es = btn_start & ~p_start;
            ep = btn_stop & ~p_stop;
            el = btn_load & ~p_load;
            for (int i = 0; i < 2; i++) begin
                td = (i == 0) ? 4 : 1;
                m_done[i] = 0; m_load[i] = 0; m_en[i] = 0;
                if (!m_busy[i]) begin
                    if (ep) begin
                    end else if (el) begin
                        m_data[i] = sw; m_load[i] = 1;
                    end else if (es) begin
                        m_busy[i] = 1; m_t[i] = m_cyc; m_n[i] = int'(sw[7:5]);
                        m_steps[i] = int'(sw[7:5]); m_amt[i] = int'(sw[2:0]);
                        m_dir[i] = sw[3]; m_rot[i] = sw[4];
                    end
                end else begin
                    k = m_cyc - m_t[i];
                    if (ep) begin
                        m_busy[i] = 0;
                    end else if (m_n[i] != 0 && k == m_n[i] * td + 1) begin
                        m_busy[i] = 0; m_done[i] = 1;
                    end else begin
                        m_en[i] = (k % td == 0);
                        m_steps[i] = (m_n[i] != 0) ? m_n[i] - k / td : 0;
                    end
                end
            end
            p_start = btn_start; p_stop = btn_stop; p_load = btn_load;
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
                chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
                chk($sformatf("sh_load%0d", i), 32'(sh_load[i]), 32'(m_load[i]));
                chk($sformatf("sh_load_data%0d", i), 32'(ld[i]), 32'(m_data[i]));
                chk($sformatf("sh_en%0d", i), 32'(sh_en[i]), 32'(m_en[i]));
                chk($sformatf("sh_dir%0d", i), 32'(sh_dir[i]), 32'(m_dir[i]));
                chk($sformatf("sh_rot%0d", i), 32'(sh_rot[i]), 32'(m_rot[i]));
                chk($sformatf("sh_amt%0d", i), 32'(amt[i]), 32'(m_amt[i]));
                chk($sformatf("steps_left%0d", i), 32'(steps[i]), 32'(m_steps[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_busy"}, 32'(busy[i]), 32'd0);
            chk({nm, "_done"}, 32'(done[i]), 32'd0);
            chk({nm, "_load"}, 32'(sh_load[i]), 32'd0);
            chk({nm, "_data"}, 32'(ld[i]), 32'd0);
            chk({nm, "_en"}, 32'(sh_en[i]), 32'd0);
            chk({nm, "_cfg"}, {26'd0, sh_dir[i], sh_rot[i], amt[i], 1'b0}, 32'd0);
            chk({nm, "_steps"}, 32'(steps[i]), 32'd0);
        end
    endtask

    task automatic pulse_start(input logic [7:0] v);
        tick(); sw = v; btn_start = 1'b1;
        tick(); btn_start = 1'b0;
    endtask

    int en_cnt;

    initial begin
        rst_n = 1'b0; sw = 8'h00;
        btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1; cmp_on = 1'b1;
        tick();

        // load in IDLE
        sw = 8'hA5; btn_load = 1'b1;
        tick(); btn_load = 1'b0;
        chk("load_pulse", 32'(sh_load[0]), 32'd1);
        chk("load_data", 32'(ld[0]), 32'hA5);
        tick();
        chk("load_one_cycle", 32'(sh_load[0]), 32'd0);
        chk("load_held", 32'(ld[0]), 32'hA5);

        // counted run N=3, amt 2, right, rotate; load attempt mid-run
        pulse_start(8'b011_1_1_010);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("cnt_en_j%0d", j), 32'(sh_en[0]), 32'(j == 4 || j == 8 || j == 12));
            if (j == 4 || j == 8 || j == 12) chk("cnt_steps", 32'(steps[0]), 32'((12 - j) / 4));
            chk($sformatf("cnt_done_j%0d", j), 32'(done[0]), 32'(j == 13));
            chk($sformatf("cnt_busy_j%0d", j), 32'(busy[0]), 32'(j < 13));
            chk($sformatf("td1_en_j%0d", j), 32'(sh_en[1]), 32'(j >= 1 && j <= 3));
            chk($sformatf("td1_done_j%0d", j), 32'(done[1]), 32'(j == 4));
            if (j == 1) begin sw = 8'hFF; btn_load = 1'b1; end
            else if (j == 2) btn_load = 1'b0;
            tick();
        end
        chk("cnt_amt", 32'(amt[0]), 32'd2);
        chk("cnt_dir_rot", {30'd0, sh_dir[0], sh_rot[0]}, 32'd3);
        chk("run_load_ignored", 32'(ld[0]), 32'hA5);

        // continuous run, stop aligned with the 5th strobe
        pulse_start(8'h05);
        en_cnt = 0;
        for (int j = 0; j < 25; j++) begin
            if (sh_en[0]) en_cnt++;
            chk("cont_done", 32'(done[0]), 32'd0);
            chk($sformatf("cont_busy_j%0d", j), 32'(busy[0]), 32'(j < 20));
            if (j == 19) btn_stop = 1'b1;
            else if (j == 20) btn_stop = 1'b0;
            tick();
        end
        chk("cont_strobes", 32'(en_cnt), 32'd4);

        // start + load together -> load only
        sw = 8'h3C; btn_start = 1'b1; btn_load = 1'b1;
        tick(); btn_start = 1'b0; btn_load = 1'b0;
        chk("sim_load", 32'(sh_load[0]), 32'd1);
        chk("sim_nobusy", 32'(busy[0]), 32'd0);
        chk("sim_data", 32'(ld[0]), 32'h3C);
        tick();
        // stop + start together -> nothing
        btn_stop = 1'b1; btn_start = 1'b1;
        tick(); btn_stop = 1'b0; btn_start = 1'b0;
        chk("stopstart_busy", 32'(busy[0]), 32'd0);
        chk("stopstart_load", 32'(sh_load[0]), 32'd0);
        tick();

        // start edge in the done cycle
        pulse_start(8'h20);
        for (int j = 0; j < 16; j++) begin
            if (j == 5) begin
                chk("dc_done", 32'(done[0]), 32'd1);
                chk("dc_busy_low", 32'(busy[0]), 32'd0);
                btn_start = 1'b1;
            end else if (j == 6) begin
                chk("dc_restart_busy", 32'(busy[0]), 32'd1);
                btn_start = 1'b0;
            end
            tick();
        end

        // TICK_DIV=1, N=7
        pulse_start(8'hE0);
        en_cnt = 0;
        for (int j = 0; j < 36; j++) begin
            if (j < 10) begin
                chk($sformatf("n7_en_j%0d", j), 32'(sh_en[1]), 32'(j >= 1 && j <= 7));
                chk($sformatf("n7_done_j%0d", j), 32'(done[1]), 32'(j == 8));
            end
            if (sh_en[1]) en_cnt++;
            tick();
        end
        chk("n7_strobes", 32'(en_cnt), 32'd7);

        // reset mid-run with btn_start held across release
        pulse_start(8'hE3);
        repeat (6) tick();
        btn_start = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        tick(); rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("held_start_busy0", 32'(busy[0]), 32'd0);
            chk("held_start_busy1", 32'(busy[1]), 32'd0);
        end
        btn_start = 1'b0;
        tick();

        // randomized stimulus
        for (int j = 0; j < 3000; j++) begin
            tick();
            sw        = 8'($urandom);
            btn_start = ($urandom_range(0, 5) == 0);
            btn_load  = ($urandom_range(0, 9) == 0);
            btn_stop  = ($urandom_range(0, 39) == 0);
        end
        tick();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
